simple_mem_responder: RTL and testbench
=======================================

SIMPLE_MEM_RESPONDER -- requirements
Module: simple_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words stored; power of two, 2..65536.
REQ-002 Parameter INIT_ZERO, default 1; 1 = array cleared during the LOAD state before the first load word is accepted.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous assertion, active-low.
REQ-005 i_memAddr  input  16  word address from the processor.
REQ-006 i_memData  input  16  write data from the processor.
REQ-007 i_memWrEnable  input  1  processor write strobe; 0 = read.
REQ-008 o_memData  output  16  registered read data to the processor.
REQ-009 i_ldValid  input  1  loader word valid.
REQ-010 i_ldData  input  16  loader word.
REQ-011 i_ldLast  input  1  marks the final loader word; qualified by i_ldValid.
REQ-012 o_ldReady  output  1  loader word accepted when i_ldValid && o_ldReady.
REQ-013 o_run  output  1  1 = processor port active.
REQ-014 o_addrErr  output  1  sticky out-of-range access flag.

Function
REQ-015 The FSM SHALL have the states CLEAR, LOAD and RUN, and SHALL enter CLEAR after reset when INIT_ZERO=1, otherwise LOAD.
REQ-016 CLEAR: the block SHALL write 0 to one word per cycle from address 0 to DEPTH-1, then go to LOAD; o_ldReady=0 throughout.
REQ-017 LOAD: o_ldReady=1; each accepted word SHALL be written to mem[ldPtr], after which ldPtr increments by 1.
REQ-018 LOAD SHALL exit to RUN on the cycle after a word is accepted with i_ldLast=1, or after the word is accepted at ldPtr=DEPTH-1, whichever comes first; ldPtr does not wrap.
REQ-019 o_run SHALL be 1 only in RUN; RUN is left only by reset.
REQ-020 Outside RUN, processor writes SHALL be ignored and o_memData SHALL hold 0.
REQ-021 RUN read: o_memData SHALL equal mem[i_memAddr] sampled at edge N and SHALL be visible after edge N (1-cycle latency).
REQ-022 RUN write (i_memWrEnable=1): mem[i_memAddr] <= i_memData at the edge.
REQ-023 Read during write to the same address SHALL be read-first: o_memData shows the old contents.
REQ-024 An address >= DEPTH SHALL have its write dropped, SHALL return 0 on the next cycle, and SHALL set o_addrErr, which stays 1 until reset.
REQ-025 Loader inputs SHALL be ignored in RUN and CLEAR.

Reset
REQ-026 i_rst low SHALL immediately force: state=CLEAR or LOAD per INIT_ZERO, ldPtr=0, clear pointer=0, o_memData=0, o_ldReady=0, o_run=0, o_addrErr=0.
REQ-027 Array contents SHALL NOT be reset; a reset mid-LOAD restarts loading at address 0.
REQ-028 o_ldReady SHALL rise no earlier than the first edge after i_rst deasserts.

Structure
REQ-029 The package simple_mem_pkg SHALL hold DATA_W=16, ADDR_W=16 and the enum mem_state_t {CLEAR, LOAD, RUN}.
REQ-030 The storage SHALL be a sub-module, simple_mem_array: single-port synchronous read-first RAM with no reset; the FSM, write-port mux and range check stay in the top level.

Verification
REQ-031 DEPTH=256, INIT_ZERO=1: reset, then load 3 words 0x1111, 0x2222, 0x3333 (last on the third) -> o_run=1 after 256 CLEAR cycles + 3 accepts + 1; reading address 1 returns 0x2222 one cycle later; address 5 returns 0x0000.
REQ-032 RUN: write 0xBEEF to address 0x0010 while reading the same address -> that cycle returns the old value (0x0000); the next read returns 0xBEEF.
REQ-033 RUN: write 0x1234 to address 0x0100 -> o_addrErr=1 permanently; reading 0x0100 returns 0x0000; reading 0x0000 still returns 0x1111.
REQ-034 INIT_ZERO=0: stream 256 words without i_ldLast -> exactly 256 accepts; o_ldReady drops; o_run=1; word 255 reads back correctly.
REQ-035 Assert i_rst mid-LOAD after 2 accepts, release, load 0xAAAA with last -> address 0 reads 0xAAAA; all outputs observed at 0 while reset is low.
REQ-036 In LOAD, pulse i_memWrEnable with address 0 and data 0xFFFF -> after RUN, address 0 holds the loaded value, not 0xFFFF.

Source files
------------

// File: rtl/simple_mem_pkg.sv
// Shared definitions for the simple memory responder: bus widths, the
// controller state encoding, the RAM write-port payload and a range helper.
package simple_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  // Controller phases: zero the array, accept loader words, serve the processor.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } mem_state_t;

  // One write-port transaction presented to the storage array.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // True when a processor word address falls inside an array of 'depth' words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/simple_mem_responder_if.sv
// Processor and loader signal bundle for simple_mem_responder.
//   master : processor/loader side (drives i_*, observes o_*)
//   slave  : the responder (observes i_*, drives o_*)
// Signals:
//   i_memAddr/i_memData/i_memWrEnable : processor word address, write data, write strobe
//   o_memData                         : read data, one cycle after the address
//   i_ldValid/i_ldData/i_ldLast       : loader word stream
//   o_ldReady                         : loader word accepted when i_ldValid && o_ldReady
//   o_run                             : processor port active
//   o_addrErr                         : sticky out-of-range access flag
interface simple_mem_responder_if;
  import simple_mem_pkg::*;

  logic [ADDR_W-1:0] i_memAddr;
  logic [DATA_W-1:0] i_memData;
  logic              i_memWrEnable;
  logic [DATA_W-1:0] o_memData;
  logic              i_ldValid;
  logic [DATA_W-1:0] i_ldData;
  logic              i_ldLast;
  logic              o_ldReady;
  logic              o_run;
  logic              o_addrErr;

  modport master (
    output i_memAddr, i_memData, i_memWrEnable, i_ldValid, i_ldData, i_ldLast,
    input  o_memData, o_ldReady, o_run, o_addrErr
  );

  modport slave (
    input  i_memAddr, i_memData, i_memWrEnable, i_ldValid, i_ldData, i_ldLast,
    output o_memData, o_ldReady, o_run, o_addrErr
  );

endinterface

// File: rtl/simple_mem_array.sv
// Single-port synchronous RAM, read-first, no reset on contents or read data.
// Ports:
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents when writing the same word)
module simple_mem_array
  import simple_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
  input  logic [DATA_W-1:0]                    wdata,
  output logic [DATA_W-1:0]                    rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read and write share the edge; rdata takes the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/simple_mem_responder.sv
// Memory responder: optionally zeroes its array, accepts an initial image
// from a loader stream, then serves processor reads/writes with one cycle
// of read latency and a sticky out-of-range flag.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : processor + loader bundle (simple_mem_responder_if.slave)
module simple_mem_responder
  import simple_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  simple_mem_responder_if.slave   bus
);

  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam mem_state_t RESET_STATE  = INIT_ZERO ? CLEAR : LOAD;

  mem_state_t        state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]     ld_ptr_q, ld_ptr_d;
  logic              addr_err_q, addr_err_d;
  logic              rd_ok_q, rd_ok_d;
  logic              ld_ready_q;
  logic              run_q;
  mem_wr_t           wr;
  logic [DATA_W-1:0] ram_rdata;
  logic              in_range;
  logic              ld_accept;

  assign in_range  = addr_in_range(bus.i_memAddr, DEPTH);
  // Ready is registered, so the very first cycle after reset never accepts.
  assign ld_accept = bus.i_ldValid && ld_ready_q;

  // State and bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= RESET_STATE;
      clr_ptr_q  <= '0;
      ld_ptr_q   <= '0;
      addr_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      ld_ready_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_ptr_q   <= ld_ptr_d;
      addr_err_q <= addr_err_d;
      rd_ok_q    <= rd_ok_d;
      ld_ready_q <= (state_d == LOAD);
      run_q      <= (state_d == RUN);
    end
  end

  // Next-state and write-port selection.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_ptr_d   = ld_ptr_q;
    addr_err_d = addr_err_q;
    rd_ok_d    = 1'b0;
    wr         = '0;

    case (state_q)
      CLEAR: begin
        wr.we     = 1'b1;
        wr.addr   = ADDR_W'(clr_ptr_q);
        wr.data   = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        wr.addr = ADDR_W'(ld_ptr_q);
        wr.data = bus.i_ldData;
        if (ld_accept) begin
          wr.we = 1'b1;
          // Last word or full array: leave without wrapping the pointer.
          if (bus.i_ldLast || (ld_ptr_q == LAST_ADDR)) begin
            state_d = RUN;
          end else begin
            ld_ptr_d = ld_ptr_q + AW'(1);
          end
        end
      end

      RUN: begin
        wr.addr = bus.i_memAddr;
        wr.data = bus.i_memData;
        wr.we   = bus.i_memWrEnable && in_range;
        rd_ok_d = in_range;
        if (!in_range) begin
          addr_err_d = 1'b1;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  simple_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (i_clk),
    .we    (wr.we),
    .addr  (AW'(wr.addr)),
    .wdata (wr.data),
    .rdata (ram_rdata)
  );

  // RAM output is unreset; a reset flag gates it to zero outside valid reads.
  assign bus.o_memData = rd_ok_q ? ram_rdata : '0;
  assign bus.o_ldReady = ld_ready_q;
  assign bus.o_run     = run_q;
  assign bus.o_addrErr = addr_err_q;

endmodule

// File: tb/tb_simple_mem_responder.sv
module tb_simple_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT stimulus and observed outputs: index 0 is INIT_ZERO=1, index 1 is INIT_ZERO=0.
  logic        rst   [2];
  logic [15:0] addr  [2];
  logic [15:0] wdat  [2];
  logic        we    [2];
  logic        ldv   [2];
  logic [15:0] lddat [2];
  logic        ldl   [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        run   [2];
  logic        err   [2];

  simple_mem_responder_if bus0 ();
  simple_mem_responder_if bus1 ();

  assign bus0.i_memAddr     = addr[0];
  assign bus0.i_memData     = wdat[0];
  assign bus0.i_memWrEnable = we[0];
  assign bus0.i_ldValid     = ldv[0];
  assign bus0.i_ldData      = lddat[0];
  assign bus0.i_ldLast      = ldl[0];
  assign rdata[0]           = bus0.o_memData;
  assign rdy[0]             = bus0.o_ldReady;
  assign run[0]             = bus0.o_run;
  assign err[0]             = bus0.o_addrErr;

  assign bus1.i_memAddr     = addr[1];
  assign bus1.i_memData     = wdat[1];
  assign bus1.i_memWrEnable = we[1];
  assign bus1.i_ldValid     = ldv[1];
  assign bus1.i_ldData      = lddat[1];
  assign bus1.i_ldLast      = ldl[1];
  assign rdata[1]           = bus1.o_memData;
  assign rdy[1]             = bus1.o_ldReady;
  assign run[1]             = bus1.o_run;
  assign err[1]             = bus1.o_addrErr;

  simple_mem_responder #(.DEPTH(256), .INIT_ZERO(1'b1)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst[0]),
    .bus   (bus0)
  );

  simple_mem_responder #(.DEPTH(256), .INIT_ZERO(1'b0)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst[1]),
    .bus   (bus1)
  );

  // Behavioural model: a word array, a count of words still to clear,
  // the loader fill pointer, and the observable flags.
  logic [15:0] m_mem   [2][256];
  bit          m_known [2][256];
  int          m_clr   [2];
  int          m_ptr   [2];
  bit          m_run   [2];
  bit          m_err   [2];
  bit          m_rdy   [2];
  logic [15:0] m_rd    [2];
  bit          m_rdk   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        m_clr[d] = (d == 0) ? 256 : 0;
        m_ptr[d] = 0;
        m_run[d] = 1'b0;
        m_err[d] = 1'b0;
        m_rdy[d] = 1'b0;
        m_rd[d]  = 16'h0000;
        m_rdk[d] = 1'b1;
      end else begin
        if (m_run[d]) begin
          if (int'(addr[d]) < 256) begin
            m_rd[d]  = m_mem[d][int'(addr[d])];
            m_rdk[d] = m_known[d][int'(addr[d])];
            if (we[d]) begin
              m_mem[d][int'(addr[d])]   = wdat[d];
              m_known[d][int'(addr[d])] = 1'b1;
            end
          end else begin
            m_rd[d]  = 16'h0000;
            m_rdk[d] = 1'b1;
            m_err[d] = 1'b1;
          end
        end else begin
          m_rd[d]  = 16'h0000;
          m_rdk[d] = 1'b1;
          if (m_clr[d] > 0) begin
            m_mem[d][256 - m_clr[d]]   = 16'h0000;
            m_known[d][256 - m_clr[d]] = 1'b1;
            m_clr[d]--;
          end else if (ldv[d] && m_rdy[d]) begin
            m_mem[d][m_ptr[d]]   = lddat[d];
            m_known[d][m_ptr[d]] = 1'b1;
            if (ldl[d] || m_ptr[d] == 255) m_run[d] = 1'b1;
            else m_ptr[d]++;
          end
        end
        m_rdy[d] = !m_run[d] && (m_clr[d] == 0);
      end
    end
  end

  // Directed expectations posted by the stimulus, checked at the next falling edge.
  // sig: 0 o_memData, 1 o_ldReady, 2 o_run, 3 o_addrErr, 4 value carried in q_act.
  string       q_name [64];
  int          q_dut  [64];
  int          q_sig  [64];
  logic [31:0] q_exp  [64];
  logic [31:0] q_act  [64];
  int          q_wr = 0;
  int          q_rd = 0;
  bit          chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        if (!rst[d]) begin
          check("rst_rdata", d, 32'(rdata[d]), 32'h0);
          check("rst_ready", d, 32'(rdy[d]), 32'h0);
          check("rst_run",   d, 32'(run[d]), 32'h0);
          check("rst_err",   d, 32'(err[d]), 32'h0);
        end else begin
          check("ready", d, 32'(rdy[d]), 32'(m_rdy[d]));
          check("run",   d, 32'(run[d]), 32'(m_run[d]));
          check("err",   d, 32'(err[d]), 32'(m_err[d]));
          if (m_rdk[d]) check("rdata", d, 32'(rdata[d]), 32'(m_rd[d]));
        end
      end
    end
    while (q_rd != q_wr) begin
      int i;
      logic [31:0] a;
      i = q_rd % 64;
      case (q_sig[i])
        0:       a = 32'(rdata[q_dut[i]]);
        1:       a = 32'(rdy[q_dut[i]]);
        2:       a = 32'(run[q_dut[i]]);
        3:       a = 32'(err[q_dut[i]]);
        default: a = q_act[i];
      endcase
      check(q_name[i], q_dut[i], a, q_exp[i]);
      q_rd++;
    end
  end

  task automatic expect_sig(input int d, input int sig, input logic [31:0] exp, input string nm);
    q_name[q_wr % 64] = nm;
    q_dut[q_wr % 64]  = d;
    q_sig[q_wr % 64]  = sig;
    q_exp[q_wr % 64]  = exp;
    q_act[q_wr % 64]  = 32'h0;
    q_wr++;
  endtask

  task automatic expect_val(input logic [31:0] act, input logic [31:0] exp, input string nm);
    q_name[q_wr % 64] = nm;
    q_dut[q_wr % 64]  = 0;
    q_sig[q_wr % 64]  = 4;
    q_exp[q_wr % 64]  = exp;
    q_act[q_wr % 64]  = act;
    q_wr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all_zero(input int d, input string nm);
    expect_sig(d, 0, 32'h0, {nm, "_rdata"});
    expect_sig(d, 1, 32'h0, {nm, "_ready"});
    expect_sig(d, 2, 32'h0, {nm, "_run"});
    expect_sig(d, 3, 32'h0, {nm, "_err"});
  endtask

  initial begin
    int cnt;
    int acc;
    logic r;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; addr[d] = 16'h0; wdat[d] = 16'h0; we[d] = 1'b0;
      ldv[d] = 1'b0; lddat[d] = 16'h0; ldl[d] = 1'b0;
    end
    #2;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_on = 1'b1;
    repeat (3) tick();

    // INIT_ZERO=1: clear, then load three words.
    rst[0] = 1'b1;
    cnt = 0;
    while (!rdy[0] && cnt < 400) begin
      tick();
      cnt++;
    end
    expect_val(32'(cnt), 32'd256, "clear_cycles");
    ldv[0] = 1'b1; lddat[0] = 16'h1111; ldl[0] = 1'b0; tick();
    lddat[0] = 16'h2222; tick();
    expect_sig(0, 2, 32'h0, "run_before_last");
    lddat[0] = 16'h3333; ldl[0] = 1'b1; tick();
    ldv[0] = 1'b0; ldl[0] = 1'b0;
    expect_sig(0, 2, 32'h1, "run_after_last");
    expect_sig(0, 1, 32'h0, "ready_in_run");
    addr[0] = 16'h0001; tick(); expect_sig(0, 0, 32'h2222, "rd_addr1");
    addr[0] = 16'h0005; tick(); expect_sig(0, 0, 32'h0000, "rd_addr5");
    addr[0] = 16'h0000; tick(); expect_sig(0, 0, 32'h1111, "rd_addr0");

    // Read-first on a simultaneous write.
    addr[0] = 16'h0010; wdat[0] = 16'hBEEF; we[0] = 1'b1; tick();
    we[0] = 1'b0;
    expect_sig(0, 0, 32'h0000, "rfw_old");
    tick(); expect_sig(0, 0, 32'hBEEF, "rfw_new");

    // Loader traffic in RUN must not touch the array.
    ldv[0] = 1'b1; lddat[0] = 16'h5555; ldl[0] = 1'b1; addr[0] = 16'h0003; tick();
    expect_sig(0, 0, 32'h0000, "ld_ignored_a");
    ldv[0] = 1'b0; ldl[0] = 1'b0; tick();
    expect_sig(0, 0, 32'h0000, "ld_ignored_b");

    // Out-of-range write: dropped, reads 0, sticky error.
    expect_sig(0, 3, 32'h0, "err_clear");
    addr[0] = 16'h0100; wdat[0] = 16'h1234; we[0] = 1'b1; tick();
    we[0] = 1'b0;
    expect_sig(0, 3, 32'h1, "err_set");
    expect_sig(0, 0, 32'h0000, "oor_wr_rd");
    tick(); expect_sig(0, 0, 32'h0000, "oor_rd");
    addr[0] = 16'h0000; tick();
    expect_sig(0, 0, 32'h1111, "rd0_after_oor");
    expect_sig(0, 3, 32'h1, "err_sticky");
    repeat (5) tick();
    expect_sig(0, 3, 32'h1, "err_sticky2");

    // INIT_ZERO=0: stream a full array without a last marker.
    rst[1] = 1'b1;
    expect_sig(1, 1, 32'h0, "ready_before_edge");
    tick();
    expect_sig(1, 1, 32'h1, "ready_first_edge");
    acc = 0; cnt = 0;
    ldv[1] = 1'b1; ldl[1] = 1'b0;
    while (!run[1] && cnt < 300) begin
      lddat[1] = 16'h8000 | 16'(acc);
      r = rdy[1];
      tick();
      if (r) acc++;
      cnt++;
    end
    ldv[1] = 1'b0;
    expect_val(32'(acc), 32'd256, "accepts");
    expect_sig(1, 2, 32'h1, "run_full");
    expect_sig(1, 1, 32'h0, "ready_drop");
    addr[1] = 16'h00FF; tick(); expect_sig(1, 0, 32'h80FF, "rd_addr255");
    addr[1] = 16'h0002; tick(); expect_sig(1, 0, 32'h8002, "rd_addr2");

    // Reset in RUN clears outputs immediately.
    addr[1] = 16'h0000; tick();
    rst[1] = 1'b0;
    expect_all_zero(1, "rst_async");
    tick(); tick();
    rst[1] = 1'b1; tick();

    // Two accepts, then reset mid-LOAD.
    ldv[1] = 1'b1; lddat[1] = 16'h1234; tick();
    lddat[1] = 16'h4321; tick();
    ldv[1] = 1'b0;
    rst[1] = 1'b0;
    expect_all_zero(1, "midload_rst");
    tick(); tick();
    rst[1] = 1'b1; tick();

    // Processor write during LOAD is ignored; reload restarts at address 0.
    addr[1] = 16'h0000; wdat[1] = 16'hFFFF; we[1] = 1'b1; tick();
    we[1] = 1'b0;
    ldv[1] = 1'b1; lddat[1] = 16'hAAAA; ldl[1] = 1'b1; tick();
    ldv[1] = 1'b0; ldl[1] = 1'b0;
    expect_sig(1, 2, 32'h1, "run_reload");
    addr[1] = 16'h0000; tick(); expect_sig(1, 0, 32'hAAAA, "rd0_reload");
    addr[1] = 16'h0001; tick(); expect_sig(1, 0, 32'h4321, "rd1_kept");
    addr[1] = 16'h0002; tick(); expect_sig(1, 0, 32'h8002, "rd2_kept");

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
